uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` serializer between `N_REQ` byte-stream requesters. It accepts one word at a time through a valid/ready handshake and launches it with a single-cycle `uart_tx_en` pulse. It then tracks `uart_tx_busy` through the whole frame and inserts an optional idle gap before granting the next requester. It sits between the AXI-side command/FIFO logic and the `uart_tx` instance.

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one uart_tx serializer among
//               N_REQ byte-stream requesters. It accepts one word per frame,
//               launches it with a single-cycle enable pulse, follows the
//               serializer busy flag through the frame and optionally idles
//               for GAP_CYCLES before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter  int N_REQ        = 4,
  parameter  int PAYLOAD_BITS = 8,
  parameter  int GAP_CYCLES   = 0,
  localparam int ID_W         = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]       uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic                          active,
  output logic [ID_W-1:0]               cur_id
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  localparam logic [ID_W:0] c_n_req      = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] c_last_id  = ID_W'(N_REQ - 1);
  localparam logic          c_has_gap    = (GAP_CYCLES > 0);
  localparam logic [15:0]   c_gap_load   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  // Busy must appear within four cycles of entering S_WAIT_BUSY.
  localparam logic [1:0]    c_wdog_last  = 2'd3;

  state_t                  r_state;
  state_t                  w_next;
  logic [ID_W-1:0]         r_last_grant;
  logic [ID_W-1:0]         r_cur_id;
  logic                    r_tx_en;
  logic [PAYLOAD_BITS-1:0] r_tx_data;
  logic [1:0]              r_wdog;
  logic [15:0]             r_gap_cnt;

  logic                    w_found;
  logic [ID_W-1:0]         w_winner;
  logic [ID_W:0]           w_sum;
  logic [N_REQ-1:0]        w_ready;
  logic                    w_accept;
  logic                    w_gap_load;

  // Round-robin search: first valid requester after the last grant, with
  // modulo-N_REQ wrap so non-power-of-two counts work.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, r_last_grant} + (ID_W+1)'(k);
      if (w_sum >= c_n_req) begin
        w_sum = w_sum - c_n_req;
      end
      if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[ID_W-1:0];
      end
    end
  end

  // Next-state decode and the combinational one-hot accept strobe.
  always_comb begin
    w_next     = r_state;
    w_ready    = '0;
    w_gap_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (resetn && w_found && !uart_tx_busy) begin
          w_ready[w_winner] = 1'b1;
          w_next            = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_wdog == c_wdog_last) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (c_has_gap) begin
            w_next     = S_GAP;
            w_gap_load = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 16'd0) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = |w_ready;

  // State, pointer, launch register, watchdog and gap counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= c_last_id;
      r_cur_id     <= '0;
      r_tx_en      <= 1'b0;
      r_tx_data    <= '0;
      r_wdog       <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_tx_en <= w_accept;
      if (w_accept) begin
        r_tx_data    <= req_data[int'(w_winner)*PAYLOAD_BITS +: PAYLOAD_BITS];
        r_last_grant <= w_winner;
        r_cur_id     <= w_winner;
      end
      if (r_state == S_WAIT_BUSY) begin
        r_wdog <= r_wdog + 2'd1;
      end else begin
        r_wdog <= '0;
      end
      if (w_gap_load) begin
        r_gap_cnt <= c_gap_load;
      end else if (r_state == S_GAP && r_gap_cnt != 16'd0) begin
        r_gap_cnt <= r_gap_cnt - 16'd1;
      end
    end
  end

  assign req_ready    = w_ready;
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign active       = (r_state != S_IDLE);
  assign cur_id       = r_cur_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Two instances (no gap
//               and a 10-cycle gap) share the requester stimulus; each has its
//               own simple serializer stand-in that holds busy for a fixed
//               frame length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int L   = 12;
  localparam int BIG = 32'h3fff_ffff;

  logic           clk       = 1'b0;
  logic           resetn    = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic           ext_busy  = 1'b0;
  logic           mute      = 1'b0;

  logic [N-1:0] ready [2];
  logic         en    [2];
  logic [W-1:0] tdata [2];
  logic         busy  [2];
  logic         act   [2];
  logic [1:0]   cid   [2];
  logic         ubusy [2];
  int           ucnt  [2];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  // Model state, one entry per instance
  int           m_ready_at [2];
  int           m_ptr      [2];
  int           m_cid      [2];
  int           m_acc      [2];
  int           m_phase    [2];
  logic [W-1:0] m_data     [2];

  int           seq_id [5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] seq_d  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  uart_tx_arbiter #(.N_REQ(N), .PAYLOAD_BITS(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready[0]), .uart_tx_en(en[0]), .uart_tx_data(tdata[0]),
    .uart_tx_busy(busy[0]), .active(act[0]), .cur_id(cid[0]));

  uart_tx_arbiter #(.N_REQ(N), .PAYLOAD_BITS(W), .GAP_CYCLES(10)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready[1]), .uart_tx_en(en[1]), .uart_tx_data(tdata[1]),
    .uart_tx_busy(busy[1]), .active(act[1]), .cur_id(cid[1]));

  assign busy[0] = ubusy[0] | ext_busy;
  assign busy[1] = ubusy[1] | ext_busy;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer stand-in: busy rises the cycle after the enable pulse and lasts L cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        ubusy[i] <= 1'b0;
        ucnt[i]  <= 0;
      end else if (en[i] && !mute) begin
        ubusy[i] <= 1'b1;
        ucnt[i]  <= L;
      end else if (ucnt[i] > 1) begin
        ucnt[i] <= ucnt[i] - 1;
      end else begin
        ucnt[i]  <= 0;
        ubusy[i] <= 1'b0;
      end
    end
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 10;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at cycle %0d", name, inst, a, e, cyc);
  endtask

  // Per-cycle comparison against a frame-level model: an instance is free to
  // accept from m_ready_at on, which is set from the observed busy edges.
  always @(negedge clk) begin
    logic [N-1:0] er;
    int           win;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        chk("ready_in_reset", i, 32'(ready[i]), 32'd0);
        m_ready_at[i] = cyc + 1;
        m_ptr[i]      = N - 1;
        m_cid[i]      = 0;
        m_acc[i]      = -100;
        m_phase[i]    = 0;
        m_data[i]     = '0;
      end else begin
        er  = '0;
        win = -1;
        if (cyc >= m_ready_at[i] && busy[i] === 1'b0 && req_valid != '0) begin
          for (int k = 1; k <= N; k++)
            if (win < 0 && req_valid[(m_ptr[i] + k) % N]) win = (m_ptr[i] + k) % N;
          er[win] = 1'b1;
        end
        chk("req_ready", i, 32'(ready[i]), 32'(er));
        chk("tx_en",     i, 32'(en[i]),    (cyc == m_acc[i] + 1) ? 32'd1 : 32'd0);
        chk("tx_data",   i, 32'(tdata[i]), 32'(m_data[i]));
        chk("active",    i, 32'(act[i]),   (cyc < m_ready_at[i]) ? 32'd1 : 32'd0);
        chk("cur_id",    i, 32'(cid[i]),   32'(m_cid[i]));
        if (m_phase[i] == 1) begin
          if (busy[i] && cyc >= m_acc[i] + 2) begin
            m_phase[i] = 2;
          end else if (cyc == m_acc[i] + 5) begin
            m_phase[i]    = 0;
            m_ready_at[i] = cyc + 1;
          end
        end else if (m_phase[i] == 2 && !busy[i]) begin
          m_phase[i]    = 0;
          m_ready_at[i] = cyc + 1 + gap_of(i);
        end
        if (win >= 0) begin
          m_acc[i]      = cyc;
          m_ptr[i]      = win;
          m_cid[i]      = win;
          m_data[i]     = req_data[win*W +: W];
          m_phase[i]    = 1;
          m_ready_at[i] = BIG;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] v, input logic [N*W-1:0] d);
    resetn    = 1'b0;
    req_valid = v;
    req_data  = d;
    tick();
    resetn = 1'b1;
  endtask

  // Waits for an accept on one instance, then checks the launch cycle.
  task automatic grab(input int inst, output int win, output logic [N-1:0] rd, output logic [W-1:0] d);
    win = -1;
    rd  = '0;
    d   = '0;
    for (int t = 0; t < 300 && win < 0; t++) begin
      @(negedge clk);
      if ((ready[inst] & req_valid) != '0) begin
        rd = ready[inst];
        for (int k = 0; k < N; k++) if (rd[k]) win = k;
      end
    end
    if (win < 0) begin
      chk("accept_timeout", inst, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("launch_en", inst, 32'(en[inst]), 32'd1);
      d = tdata[inst];
    end
    tick();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    req_valid = '0;
    while ((act[0] || act[1]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("idle_timeout", 0, 32'd1, 32'd0);
    tick();
  endtask

  // Cycles from busy falling to the second req_ready pulse.
  task automatic gap_measure(input int inst, input int expected);
    int fall, rdy, seen;
    fall = -1;
    rdy  = -1;
    seen = 0;
    for (int t = 0; t < 200 && rdy < 0; t++) begin
      @(negedge clk);
      if (busy[inst]) seen = 1;
      else if (seen != 0 && fall < 0) fall = cyc;
      if (fall >= 0 && ready[inst] != '0) rdy = cyc;
    end
    chk("gap_cycles", inst, 32'(rdy - fall), 32'(expected));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int           w;
    logic [N-1:0] rd;
    logic [W-1:0] d;

    // Reset values
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, 32'(ready[0]), 32'd0);
    chk("rst_en",    0, 32'(en[0]),    32'd0);
    chk("rst_data",  0, 32'(tdata[0]), 32'd0);
    chk("rst_active",0, 32'(act[0]),   32'd0);
    chk("rst_cur_id",0, 32'(cid[0]),   32'd0);
    tick();

    // Single requester
    req_data  = 32'h0000_00A5;
    req_valid = 4'b0001;
    grab(0, w, rd, d);
    chk("single_id",    0, 32'(w),      32'd0);
    chk("single_ready", 0, 32'(rd),     32'h1);
    chk("single_data",  0, 32'(d),      32'hA5);
    chk("single_cur",   0, 32'(cid[0]), 32'd0);
    wait_idle();

    // All requesters held: strict rotation
    do_reset(4'b1111, 32'h1312_1110);
    for (int j = 0; j < 5; j++) begin
      grab(0, w, rd, d);
      chk("rr_id",   0, 32'(w), 32'(seq_id[j]));
      chk("rr_data", 0, 32'(d), 32'(seq_d[j]));
    end
    wait_idle();

    // Fairness with wrap: after a grant to 2, 0101 goes 0 then 2
    do_reset(4'b0100, 32'h4433_2211);
    grab(0, w, rd, d);
    chk("wrap_first", 0, 32'(w), 32'd2);
    req_valid = 4'b0101;
    grab(0, w, rd, d);
    chk("wrap_second", 0, 32'(w), 32'd0);
    chk("wrap_second_data", 0, 32'(d), 32'h11);
    grab(0, w, rd, d);
    chk("wrap_third", 0, 32'(w), 32'd2);
    chk("wrap_third_data", 0, 32'(d), 32'h33);
    wait_idle();

    // Gap: 10-cycle instance and no-gap instance
    do_reset(4'b0011, 32'h0000_BBAA);
    gap_measure(1, 11);
    wait_idle();
    do_reset(4'b0011, 32'h0000_BBAA);
    gap_measure(0, 1);
    wait_idle();

    // Withdrawn request is skipped; pointer lands on 3
    do_reset(4'b0001, 32'hDD00_CC00);
    grab(0, w, rd, d);
    req_valid = 4'b1010;
    repeat (4) tick();
    req_valid = 4'b1000;
    grab(0, w, rd, d);
    chk("withdraw_id",   0, 32'(w),      32'd3);
    chk("withdraw_data", 0, 32'(d),      32'hDD);
    chk("withdraw_cur",  0, 32'(cid[0]), 32'd3);
    wait_idle();

    // Busy already high in idle: no grant until it clears
    ext_busy  = 1'b1;
    req_valid = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      chk("ready_while_busy", 0, 32'(ready[0]), 32'd0);
    end
    tick();
    ext_busy = 1'b0;
    grab(0, w, rd, d);
    chk("after_busy_id", 0, 32'(w), 32'd0);
    wait_idle();

    // Serializer never raises busy: watchdog returns to idle
    mute      = 1'b1;
    req_valid = 4'b0001;
    grab(0, w, rd, d);
    req_valid = '0;
    for (int t = 0; t < 20 && act[0]; t++) @(negedge clk);
    chk("watchdog_release", 0, 32'(act[0]), 32'd0);
    tick();
    mute = 1'b0;
    wait_idle();

    // Reset in the middle of a frame
    req_valid = 4'b0001;
    grab(0, w, rd, d);
    for (int t = 0; t < 20 && !busy[0]; t++) @(negedge clk);
    tick();
    repeat (3) tick();
    chk("midframe_busy", 0, 32'(busy[0]), 32'd1);
    resetn    = 1'b0;
    req_valid = '0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready",  0, 32'(ready[0]), 32'd0);
    chk("mid_rst_en",     0, 32'(en[0]),    32'd0);
    chk("mid_rst_data",   0, 32'(tdata[0]), 32'd0);
    chk("mid_rst_active", 0, 32'(act[0]),   32'd0);
    chk("mid_rst_cur",    0, 32'(cid[0]),   32'd0);
    chk("mid_rst_busy",   0, 32'(busy[0]),  32'd0);
    tick();
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    grab(0, w, rd, d);
    chk("post_rst_id", 0, 32'(w), 32'd0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
